// File: rtl/clock_ui_controller_pkg.sv
// Shared constants and helpers for the front-panel sequencer: display modes,
// field selects and the auto-repeat state codes.
package clock_ui_controller_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK      = 2'd0,
        MODE_CLOCK_EDIT = 2'd1,
        MODE_STOPWATCH  = 2'd2,
        MODE_ALARM_EDIT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SELECT_NONE = 2'd0,
        SELECT_SEC  = 2'd1,
        SELECT_MIN  = 2'd2,
        SELECT_HOUR = 2'd3
    } select_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // A counter that must reach n-1 needs $clog2(n) bits; keep at least one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_edit(input mode_e m);
        return (m == MODE_CLOCK_EDIT) || (m == MODE_ALARM_EDIT);
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_CLOCK:      return MODE_CLOCK_EDIT;
            MODE_CLOCK_EDIT: return MODE_STOPWATCH;
            MODE_STOPWATCH:  return MODE_ALARM_EDIT;
            default:         return MODE_CLOCK;
        endcase
    endfunction

    function automatic select_e next_select(input select_e s);
        case (s)
            SELECT_HOUR: return SELECT_MIN;
            SELECT_MIN:  return SELECT_SEC;
            default:     return SELECT_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/clock_ui_controller_if.sv
// Button levels in, top-level clock controls out; the panel side is master.
interface clock_ui_controller_if;
    import clock_ui_controller_pkg::*;

    logic    btn_mode;
    logic    btn_select;
    logic    btn_inc;
    logic    btn_clear;
    mode_e   mode;
    select_e select;
    logic    increment;
    logic    sw_reset;

    modport master (
        output btn_mode, btn_select, btn_inc, btn_clear,
        input  mode, select, increment, sw_reset
    );

    modport slave (
        input  btn_mode, btn_select, btn_inc, btn_clear,
        output mode, select, increment, sw_reset
    );

endinterface

// File: rtl/clock_ui_controller_autorepeat.sv
// Press detector plus press-and-hold auto-repeat for a single button.
// pulse is combinational; the parent registers it onto its output.
module clock_ui_controller_autorepeat
    import clock_ui_controller_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic enable,
    output logic pulse,
    output logic press
);

    localparam int CNT_W = (cnt_width(HOLD_CYCLES) > cnt_width(REPEAT_CYCLES)) ?
                           cnt_width(HOLD_CYCLES) : cnt_width(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             btn_q;
    rep_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign press = btn & ~btn_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            btn_q   <= btn;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse   = 1'b0;
        if (!enable || !btn) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        pulse   = 1'b1;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        pulse   = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (cnt_q == REPEAT_LAST) begin
                        pulse = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clock_ui_controller.sv
// Front-panel sequencer: turns four debounced buttons into mode/select/increment
// and stopwatch reset controls, with auto-repeat, run toggling and edit timeout.
module clock_ui_controller
    import clock_ui_controller_pkg::*;
#(
    parameter int HOLD_CYCLES    = 25000000,
    parameter int REPEAT_CYCLES  = 5000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input logic                  clk,
    input logic                  reset,
    clock_ui_controller_if.slave ui
);

    localparam int                TO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            btn_mode_q, btn_select_q, btn_clear_q;
    mode_e           mode_q, mode_d;
    select_e         select_q, select_d;
    logic            run_q, run_d;
    logic            increment_q, increment_d;
    logic            sw_reset_q, sw_reset_d;
    logic [TO_W-1:0] to_q, to_d;

    logic press_mode, press_select, press_clear, press_inc;
    logic any_press, rep_enable, rep_pulse, timeout_hit;

    assign press_mode   = ui.btn_mode & ~btn_mode_q;
    assign press_select = ui.btn_select & ~btn_select_q;
    assign press_clear  = ui.btn_clear & ~btn_clear_q;
    assign any_press    = press_mode | press_select | press_clear | press_inc;

    // A same-cycle mode or select press outranks inc and also restarts the hold.
    assign rep_enable = is_edit(mode_q) & ~press_mode & ~press_select;

    clock_ui_controller_autorepeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_autorepeat (
        .clk    (clk),
        .reset  (reset),
        .btn    (ui.btn_inc),
        .enable (rep_enable),
        .pulse  (rep_pulse),
        .press  (press_inc)
    );

    assign timeout_hit = is_edit(mode_q) & ~any_press & ~ui.btn_inc & (to_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_mode_q   <= 1'b1;
            btn_select_q <= 1'b1;
            btn_clear_q  <= 1'b1;
            mode_q       <= MODE_CLOCK;
            select_q     <= SELECT_NONE;
            run_q        <= 1'b0;
            increment_q  <= 1'b0;
            sw_reset_q   <= 1'b0;
            to_q         <= '0;
        end else begin
            btn_mode_q   <= ui.btn_mode;
            btn_select_q <= ui.btn_select;
            btn_clear_q  <= ui.btn_clear;
            mode_q       <= mode_d;
            select_q     <= select_d;
            run_q        <= run_d;
            increment_q  <= increment_d;
            sw_reset_q   <= sw_reset_d;
            to_q         <= to_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        select_d   = select_q;
        run_d      = run_q;
        sw_reset_d = 1'b0;
        if (press_mode) begin
            mode_d   = next_mode(mode_q);
            select_d = is_edit(mode_d) ? SELECT_HOUR : SELECT_NONE;
        end else if (press_clear && (mode_q == MODE_STOPWATCH)) begin
            sw_reset_d = 1'b1;
            run_d      = 1'b0;
        end else if (press_select && is_edit(mode_q)) begin
            select_d = next_select(select_q);
        end else if (press_inc && (mode_q == MODE_STOPWATCH)) begin
            run_d = ~run_q;
        end else if (timeout_hit) begin
            mode_d   = MODE_CLOCK;
            select_d = SELECT_NONE;
        end

        case (mode_d)
            MODE_STOPWATCH:                   increment_d = run_d;
            MODE_CLOCK_EDIT, MODE_ALARM_EDIT: increment_d = rep_pulse;
            default:                          increment_d = 1'b0;
        endcase
    end

    // Timeout restarts on any press or while inc is held; it never wraps.
    always_comb begin
        if (!is_edit(mode_q) || any_press || ui.btn_inc || (to_q == TO_LAST)) begin
            to_d = '0;
        end else begin
            to_d = to_q + TO_W'(1);
        end
    end

    assign ui.mode      = mode_q;
    assign ui.select    = select_q;
    assign ui.increment = increment_q;
    assign ui.sw_reset  = sw_reset_q;

endmodule
